wb_chain_cfg_initiator: RTL and testbench

- Wishbone initiator that drives the 8-channel trigger-chain configuration bus (biquad or AGC port).
- Takes one command (channel mask, local address, data, read/write) and issues one classic Wishbone cycle per selected channel, lowest channel first.
- Handles ack, err and rty terminations plus a bus timeout, and returns one status/data response per channel access.
- Sits between the housekeeping/command engine and the 22-bit trigger-chain target ports.

---
 rtl/wb_chain_cfg_initiator_if.sv | 23 ++
 rtl/wb_chain_cfg_initiator.sv | 168 ++++++++++++++++
 tb/tb_wb_chain_cfg_initiator.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_chain_cfg_initiator_if.sv
// rtl/wb_chain_cfg_initiator_if.sv - classic Wishbone link to the trigger-chain config ports
interface wb_chain_cfg_initiator_if;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [21:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_ack_i;
  logic        wb_err_i;
  logic        wb_rty_i;
  logic [31:0] wb_dat_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    input  wb_ack_i, wb_err_i, wb_rty_i, wb_dat_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    output wb_ack_i, wb_err_i, wb_rty_i, wb_dat_i
  );
endinterface

// File: rtl/wb_chain_cfg_initiator.sv
// rtl/wb_chain_cfg_initiator.sv - per-channel Wishbone initiator for the trigger-chain config bus
// One command fans out into one bus cycle and one response per selected channel, lowest first.
module wb_chain_cfg_initiator #(
  parameter int CH_SHIFT  = 10,
  parameter int MAX_RETRY = 3,
  parameter int TIMEOUT   = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [7:0]  cmd_chmask_i,
  input  logic [7:0]  cmd_adr_i,
  input  logic [31:0] cmd_dat_i,
  input  logic        cmd_we_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [2:0]  rsp_ch_o,
  output logic [1:0]  rsp_status_o,
  output logic [31:0] rsp_dat_o,
  output logic        busy_o,
  wb_chain_cfg_initiator_if.master wb
);

  typedef enum logic [1:0] {IDLE, BUS, GAP, RESP} state_t;

  state_t      state, state_n;
  logic [7:0]  mask_q, mask_n, mask_rem;
  logic [7:0]  adr_q, adr_n;
  logic [31:0] dat_q, dat_n;
  logic        we_q, we_n;
  logic [2:0]  ch_q, ch_n;
  logic [3:0]  retry_q, retry_n;
  logic [15:0] tmo_q, tmo_n;
  logic        accept, rsp_hs, done;
  logic [1:0]  status_n;

  function automatic logic [2:0] lowest(input logic [7:0] m);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) r = 3'(i);
    end
    return r;
  endfunction

  assign accept   = cmd_valid_i && cmd_ready_o;
  assign rsp_hs   = rsp_valid_o && rsp_ready_i;
  assign mask_rem = mask_q & ~(8'd1 << ch_q);

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) state <= IDLE;
    else             state <= state_n;
  end

  always_comb begin
    state_n  = state;
    mask_n   = mask_q;
    adr_n    = adr_q;
    dat_n    = dat_q;
    we_n     = we_q;
    ch_n     = ch_q;
    retry_n  = retry_q;
    tmo_n    = tmo_q;
    done     = 1'b0;
    status_n = 2'b00;
    case (state)
      IDLE: begin
        if (accept) begin
          mask_n  = cmd_chmask_i;
          adr_n   = cmd_adr_i;
          dat_n   = cmd_dat_i;
          we_n    = cmd_we_i;
          ch_n    = lowest(cmd_chmask_i);
          retry_n = 4'd0;
          tmo_n   = 16'd0;
          state_n = (|cmd_chmask_i) ? BUS : IDLE;
        end
      end
      BUS: begin
        // err outranks rty, which outranks ack, when several arrive together
        if (wb.wb_err_i) begin
          done     = 1'b1;
          status_n = 2'b01;
        end else if (wb.wb_rty_i) begin
          if (retry_q == 4'(MAX_RETRY)) begin
            done     = 1'b1;
            status_n = 2'b10;
          end else begin
            retry_n = retry_q + 4'd1;
            state_n = GAP;
          end
        end else if (wb.wb_ack_i) begin
          done     = 1'b1;
          status_n = 2'b00;
        end else if (tmo_q == 16'(TIMEOUT - 1)) begin
          done     = 1'b1;
          status_n = 2'b11;
        end else begin
          tmo_n = tmo_q + 16'd1;
        end
        if (done) state_n = RESP;
      end
      GAP: begin
        tmo_n   = 16'd0;
        state_n = BUS;
      end
      RESP: begin
        if (rsp_hs) begin
          mask_n  = mask_rem;
          ch_n    = lowest(mask_rem);
          retry_n = 4'd0;
          tmo_n   = 16'd0;
          state_n = (|mask_rem) ? BUS : IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      mask_q       <= '0;
      adr_q        <= '0;
      dat_q        <= '0;
      we_q         <= 1'b0;
      ch_q         <= '0;
      retry_q      <= '0;
      tmo_q        <= '0;
      cmd_ready_o  <= 1'b0;
      busy_o       <= 1'b0;
      rsp_valid_o  <= 1'b0;
      rsp_ch_o     <= '0;
      rsp_status_o <= '0;
      rsp_dat_o    <= '0;
      wb.wb_cyc_o  <= 1'b0;
      wb.wb_stb_o  <= 1'b0;
      wb.wb_we_o   <= 1'b0;
      wb.wb_adr_o  <= '0;
      wb.wb_dat_o  <= '0;
      wb.wb_sel_o  <= '0;
    end else begin
      mask_q      <= mask_n;
      adr_q       <= adr_n;
      dat_q       <= dat_n;
      we_q        <= we_n;
      ch_q        <= ch_n;
      retry_q     <= retry_n;
      tmo_q       <= tmo_n;
      cmd_ready_o <= (state_n == IDLE) && !accept;
      busy_o      <= (state_n != IDLE);
      rsp_valid_o <= (state_n == RESP);
      if (done) begin
        rsp_ch_o     <= ch_q;
        rsp_status_o <= status_n;
        rsp_dat_o    <= (status_n == 2'b00 && !we_q) ? wb.wb_dat_i : 32'd0;
      end
      wb.wb_cyc_o <= (state_n == BUS);
      wb.wb_stb_o <= (state_n == BUS);
      wb.wb_we_o  <= (state_n == BUS) && we_n;
      wb.wb_adr_o <= (state_n == BUS) ? ((22'(ch_n) << CH_SHIFT) | 22'(adr_n)) : 22'd0;
      wb.wb_dat_o <= (state_n == BUS) ? dat_n : 32'd0;
      wb.wb_sel_o <= (state_n == BUS) ? 4'hF : 4'h0;
    end
  end

endmodule

// File: tb/tb_wb_chain_cfg_initiator.sv
// tb/tb_wb_chain_cfg_initiator.sv - scoreboard bench with scripted Wishbone target and random commands
`timescale 1ns/1ps
module tb_wb_chain_cfg_initiator;
  localparam int CH_SHIFT  = 10;
  localparam int MAX_RETRY = 3;
  localparam int TIMEOUT   = 255;
  localparam int M_ACK = 0, M_ERR = 1, M_RTY = 2, M_NONE = 3;

  typedef struct {
    int          mode;
    int          nrty;
    int          wt;
    bit          also_ack;
    logic [31:0] rdata;
    logic [21:0] adr;
    logic        we;
    logic [31:0] dat;
  } plan_t;

  typedef struct {
    logic [2:0]  ch;
    logic [1:0]  st;
    logic [31:0] dat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_chmask = '0;
  logic [7:0]  cmd_adr = '0;
  logic [31:0] cmd_dat = '0;
  logic        cmd_we = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [2:0]  rsp_ch;
  logic [1:0]  rsp_status;
  logic [31:0] rsp_dat;
  logic        busy;

  wb_chain_cfg_initiator_if bus();

  wb_chain_cfg_initiator #(.CH_SHIFT(CH_SHIFT), .MAX_RETRY(MAX_RETRY), .TIMEOUT(TIMEOUT)) dut (
    .wb_clk_i     (clk),
    .wb_rst_n_i   (rst_n),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_chmask_i (cmd_chmask),
    .cmd_adr_i    (cmd_adr),
    .cmd_dat_i    (cmd_dat),
    .cmd_we_i     (cmd_we),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_ch_o     (rsp_ch),
    .rsp_status_o (rsp_status),
    .rsp_dat_o    (rsp_dat),
    .busy_o       (busy),
    .wb           (bus)
  );

  always #5 clk = ~clk;

  int cnt = 0;
  always @(posedge clk) cnt <= cnt + 1;

  int    n_tests = 0, n_fail = 0;
  plan_t plan_q[$];
  exp_t  exp_q[$];
  int    cyc_rises = 0, cyc_rise_cnt = 0, rsp_rise_cnt = 0, acc_cnt = 0;
  int    rdy_mode = 0, stall_ch = -1, stall_len = 0, stall_cnt = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got no/unexpected event, expected the required one", name);
  endtask

  function automatic logic [1:0] exp_status(input plan_t p);
    case (p.mode)
      M_ACK:   return 2'b00;
      M_ERR:   return 2'b01;
      M_RTY:   return (p.nrty <= MAX_RETRY) ? 2'b00 : 2'b10;
      default: return 2'b11;
    endcase
  endfunction

  // Scripted target: each channel access follows the plan pushed when its command was issued.
  initial begin
    plan_t cur;
    bit    active = 0, more = 0, done_att = 0, prev_cyc = 0;
    int    att = 0, wcnt = 0, hrun = 0, lrun = 0;
    bus.wb_ack_i = 0; bus.wb_err_i = 0; bus.wb_rty_i = 0; bus.wb_dat_i = '0;
    forever begin
      @(negedge clk);
      bus.wb_ack_i = 0; bus.wb_err_i = 0; bus.wb_rty_i = 0; bus.wb_dat_i = $urandom;
      if (!rst_n) begin
        active = 0; more = 0; prev_cyc = 0; hrun = 0; lrun = 0;
        continue;
      end
      if (bus.wb_cyc_o) begin
        if (!prev_cyc) begin
          cyc_rises++;
          cyc_rise_cnt = cnt;
          if (!active) begin
            if (plan_q.size() == 0) fail_now("unexpected_bus_cycle");
            else begin
              cur = plan_q.pop_front();
              active = 1; att = 0; more = 0;
            end
          end else begin
            att++;
            check("retry_gap_cycles", 64'(lrun), 64'd1);
          end
          wcnt = 0; done_att = 0; hrun = 0;
        end
        hrun++;
        if (active) begin
          check("bus_outputs",
                {4'd0, bus.wb_stb_o, bus.wb_we_o, bus.wb_sel_o, bus.wb_adr_o, (cur.we ? bus.wb_dat_o : 32'd0)},
                {4'd0, 1'b1, cur.we, 4'hF, cur.adr, (cur.we ? cur.dat : 32'd0)});
          if (!done_att) begin
            if (wcnt < cur.wt) wcnt++;
            else begin
              case (cur.mode)
                M_ACK: begin
                  bus.wb_ack_i = 1; bus.wb_dat_i = cur.rdata; more = 0; done_att = 1;
                end
                M_ERR: begin
                  bus.wb_err_i = 1; bus.wb_ack_i = cur.also_ack; more = 0; done_att = 1;
                end
                M_RTY: begin
                  if (att < cur.nrty) begin
                    bus.wb_rty_i = 1;
                    more = (att < MAX_RETRY);
                  end else begin
                    bus.wb_ack_i = 1; bus.wb_dat_i = cur.rdata; more = 0;
                  end
                  done_att = 1;
                end
                default: ;
              endcase
            end
          end
        end
      end else begin
        if (prev_cyc) begin
          if (active && cur.mode == M_NONE) check("timeout_cyc_len", 64'(hrun), 64'(TIMEOUT));
          if (!more) active = 0;
          lrun = 0;
        end
        lrun++;
        // stray terminations while no cycle is open
        bus.wb_ack_i = ($urandom_range(3) == 0);
        bus.wb_err_i = ($urandom_range(3) == 0);
        bus.wb_rty_i = ($urandom_range(3) == 0);
      end
      prev_cyc = bus.wb_cyc_o;
    end
  end

  // Response monitor: drives rsp_ready and pops the scoreboard on each handshake.
  initial begin
    bit          pv = 0, pr = 0;
    logic [2:0]  pch = '0;
    logic [1:0]  pst = '0;
    logic [31:0] pdat = '0;
    exp_t        e;
    rsp_ready = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv = 0; pr = 0; rsp_ready = 0;
        continue;
      end
      if (rsp_valid) begin
        if (!pv) rsp_rise_cnt = cnt;
        check("no_bus_during_rsp", {63'd0, bus.wb_cyc_o}, 64'd0);
      end
      if (pv && !pr)
        check("rsp_hold", {26'd0, rsp_valid, rsp_ch, rsp_status, rsp_dat}, {26'd0, 1'b1, pch, pst, pdat});
      if (rsp_valid && stall_ch >= 0 && int'(rsp_ch) == stall_ch && stall_cnt < stall_len) begin
        rsp_ready = 0;
        stall_cnt++;
      end else begin
        rsp_ready = (rdy_mode == 0) ? 1'b1 : ($urandom_range(1) == 1);
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) fail_now("unexpected_response");
        else begin
          e = exp_q.pop_front();
          check("rsp_ch", 64'(rsp_ch), 64'(e.ch));
          check("rsp_status", 64'(rsp_status), 64'(e.st));
          check("rsp_dat", 64'(rsp_dat), 64'(e.dat));
        end
      end
      pv = rsp_valid; pr = rsp_ready; pch = rsp_ch; pst = rsp_status; pdat = rsp_dat;
    end
  end

  // mode < 0 picks a random termination script per channel.
  task automatic issue(input logic [7:0] mask, input logic [7:0] adr, input logic [31:0] dat,
                       input logic we, input int mode, input int nrty, input int wt,
                       input bit also_ack, input bit fixed_rdata);
    int    guard = 0;
    int    r;
    plan_t p;
    exp_t  e;
    @(negedge clk);
    while (!cmd_ready && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (!cmd_ready) begin
      fail_now("cmd_ready_wait");
      return;
    end
    for (int c = 0; c < 8; c++) begin
      if (mask[c]) begin
        p.mode = mode; p.nrty = nrty; p.wt = wt; p.also_ack = also_ack;
        if (mode < 0) begin
          r = $urandom_range(99);
          p.wt = $urandom_range(3);
          p.also_ack = $urandom_range(1);
          p.nrty = $urandom_range(6);
          if (r < 55) p.mode = M_ACK;
          else if (r < 70) p.mode = M_ERR;
          else if (r < 96) begin p.mode = M_RTY; p.wt = $urandom_range(1); end
          else p.mode = M_NONE;
        end
        p.rdata = fixed_rdata ? (32'h1000_0000 | 32'(c)) : $urandom;
        p.adr   = (22'(c) << CH_SHIFT) | 22'(adr);
        p.we    = we;
        p.dat   = dat;
        plan_q.push_back(p);
        e.ch  = 3'(c);
        e.st  = exp_status(p);
        e.dat = (e.st == 2'b00 && !we) ? p.rdata : 32'd0;
        exp_q.push_back(e);
      end
    end
    cmd_valid = 1; cmd_chmask = mask; cmd_adr = adr; cmd_dat = dat; cmd_we = we;
    @(posedge clk);
    #1;
    acc_cnt = cnt;
    cmd_valid = 0; cmd_chmask = $urandom; cmd_adr = $urandom; cmd_dat = $urandom; cmd_we = $urandom;
  endtask

  task automatic wait_idle(input string name);
    int guard = 0;
    @(negedge clk);
    while (!(exp_q.size() == 0 && !busy && cmd_ready) && guard < 8000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 8000) fail_now(name);
  endtask

  initial begin
    int r0;
    int guard;
    repeat (3) @(negedge clk);
    check("reset_ctrl", {53'd0, cmd_ready, rsp_valid, busy, bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_sel_o, rsp_status},
          64'd0);
    check("reset_data", {10'd0, bus.wb_adr_o, bus.wb_dat_o}, 64'd0);
    rst_n = 1;
    #1 check("ready_before_first_edge", {63'd0, cmd_ready}, 64'd0);
    @(posedge clk); #1 check("ready_after_first_edge", {63'd0, cmd_ready}, 64'd1);

    rdy_mode = 0;
    issue(8'h01, 8'h10, 32'hDEADBEEF, 1'b1, M_ACK, 0, 0, 0, 1);
    wait_idle("t1_idle");
    check("t1_cyc_latency", 64'(cyc_rise_cnt), 64'(acc_cnt));
    check("t1_rsp_latency", 64'(rsp_rise_cnt), 64'(acc_cnt + 1));

    stall_ch = 5; stall_len = 5; stall_cnt = 0;
    issue(8'hA4, 8'h20, 32'h0, 1'b0, M_ACK, 0, 0, 0, 1);
    wait_idle("t2_idle");
    check("t2_stall_cycles", 64'(stall_cnt), 64'd5);
    stall_ch = -1;

    r0 = cyc_rises;
    issue(8'h01, 8'h33, 32'h0, 1'b0, M_RTY, 15, 0, 0, 1);
    wait_idle("t3a_idle");
    check("t3_rty_exhaust_attempts", 64'(cyc_rises - r0), 64'(MAX_RETRY + 1));
    r0 = cyc_rises;
    issue(8'h01, 8'h34, 32'h0, 1'b0, M_RTY, 2, 0, 0, 1);
    wait_idle("t3b_idle");
    check("t3_rty_then_ack_attempts", 64'(cyc_rises - r0), 64'd3);

    issue(8'h01, 8'h40, 32'h0, 1'b0, M_NONE, 0, 0, 0, 1);
    wait_idle("t4a_idle");
    issue(8'h02, 8'h41, 32'h0, 1'b0, M_ERR, 0, 0, 1, 1);
    wait_idle("t4b_idle");

    r0 = cyc_rises;
    issue(8'h00, 8'h55, 32'h1234, 1'b1, M_ACK, 0, 0, 0, 1);
    check("mask0_ready_dropped", {63'd0, cmd_ready}, 64'd0);
    @(posedge clk); #1 check("mask0_ready_back", {63'd0, cmd_ready}, 64'd1);
    repeat (5) @(negedge clk);
    check("mask0_no_cycle", 64'(cyc_rises - r0), 64'd0);

    rdy_mode = 1;
    for (int i = 0; i < 40; i++) begin
      issue(8'($urandom), 8'($urandom), $urandom, 1'($urandom), -1, 0, 0, 0, 0);
    end
    wait_idle("random_idle");

    rdy_mode = 0;
    issue(8'hFF, 8'h44, 32'hCAFE_F00D, 1'b1, M_ACK, 0, 2, 0, 1);
    guard = 0;
    while (!(bus.wb_cyc_o && ((bus.wb_adr_o >> CH_SHIFT) & 22'd7) == 22'd3) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) fail_now("reset_wait_ch3");
    rst_n = 0;
    #1 check("mid_reset_outputs", {59'd0, bus.wb_cyc_o, bus.wb_stb_o, rsp_valid, cmd_ready, busy}, 64'd0);
    plan_q.delete();
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1;
    #1 check("post_reset_ready_low", {63'd0, cmd_ready}, 64'd0);
    @(posedge clk); #1 check("post_reset_idle", {62'd0, cmd_ready, busy}, 64'd2);
    r0 = cyc_rises;
    repeat (10) @(negedge clk);
    check("post_reset_no_cycle", 64'(cyc_rises - r0), 64'd0);
    check("post_reset_no_rsp", {63'd0, rsp_valid}, 64'd0);

    issue(8'h08, 8'h77, 32'h0, 1'b0, M_ACK, 0, 1, 0, 1);
    wait_idle("recover_idle");
    check("plan_queue_drained", 64'(plan_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog");
  end

endmodule
